glm_dot_unpack: RTL and testbench
=================================

# glm_dot_unpack

Consumer-side counterpart of the GLM dot-product stage. It reads a region of packed 32-bit scalar results (16 per 512-bit line, as the dot writer stores them) through the standard region-to-FIFO reader. It unpacks them lane by lane and streams one scalar per cycle into a 32-bit internal write channel for downstream update/loss stages. It runs as one instruction of the GLM pipeline, with an op_start/op_done handshake and register-supplied configuration.

## Interface
Parameters:
- LOG2_VALUES_PER_LINE, 4: lanes per line = 2^4 = 16; line width = 32 × lanes = 512.
- LOG2_FIFO_DEPTH, 6: depth of the internal line FIFO (64 lines).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- op_start  in  1  single-cycle instruction start; sampled only in STATE_IDLE.
- op_done  out  1  single-cycle pulse when the last scalar has been written.
- regs  in  3×32  regs[0][15:0] num_values; regs[1] region access properties; regs[2][0] skip_first (drop lane 0 of the first line).
- MEM_props  fifobram_interface.read  access-property memory for the region reader.
- REGION_dot_read  fifobram_interface.read  source region holding packed scalars.
- to_consumer  internal_interface(32).commonwrite_source  we/wdata out, almostfull in.

## Operation
- States: STATE_IDLE, STATE_PROCESS.
- IDLE + op_start: latch num_values, access properties and skip_first. Clear counters and line-buffer valid. Go to PROCESS. Pulse read_trigger next cycle with iterations = 1.
- IDLE + op_start with num_values == 0: no read_trigger; op_done pulses on the next cycle; stay IDLE.
- lines_needed = ceil((num_values + skip_first) / 16). The region must supply exactly that many lines; surplus lines are not read.
- Fetch: issue FIFO re (registered) when all of these hold: FIFO not empty, no re in flight, line buffer not valid, lines_fetched < lines_needed.
- On rvalid: load the line buffer and set the lane index. Lane = 1 for the first line when skip_first = 1; otherwise lane = 0.
- Emit: when the line buffer is valid and almostfull = 0:
  - Register we = 1 and wdata = line[lane×32 +: 32] (lane 0 = bits [31:0]).
  - Increment lane and values_emitted.
- The line buffer clears after lane 15 is emitted, or after the value that makes values_emitted == num_values. Remaining lanes of a partial last line are discarded.
- When values_emitted reaches num_values: op_done pulses with the final we, and the state returns to IDLE.
- op_start in PROCESS is ignored.

## Timing
- Reset values: op_done = 0, to_consumer.we = 0, wdata = 0, FIFO re = 0, read_trigger = 0, state IDLE, all counters 0, line buffer invalid. Reset is also routed to the sub-module.
- Latency: op_start at cycle 0 → read_trigger at cycle 1.
- Latency: rvalid at cycle t → first we at cycle t+1.
- Throughput: one scalar per cycle within a line. There is a 2-cycle bubble between lines (re, then rvalid).
- Backpressure: almostfull = 1 holds we = 0 and freezes lane and counters. Data is never dropped.
- Counter widths: values_emitted and lines_fetched are 16 bits. num_values = 65535 must complete without wrap.
- Reset mid-operation: immediately returns to IDLE. No op_done is produced. Any partially read line is discarded.

## Structure
- Shared package: the t_unpackstate enum, CLDATA_WIDTH, and the register-field bit positions (num_values, skip_first).
- Sub-module: read_region2fifo. It is instantiated once, with WIDTH = CLDATA_WIDTH and LOG2_DEPTH = LOG2_FIFO_DEPTH. The lane-select unpacker stays in this module.

## Test plan
- num_values = 16, one line of values 0..15 → 16 consecutive we, wdata 0..15; op_done coincides with the 16th we.
- num_values = 20, two lines → 20 we; lanes 4..15 of line 2 discarded; exactly 2 FIFO re.
- skip_first = 1, num_values = 16 → outputs line1 lanes 1..15, then line2 lane 0; 2 lines read.
- almostfull held high for 10 cycles mid-line → we = 0 throughout; output order and count unchanged after release.
- num_values = 0 → no read_trigger, op_done 1 cycle after op_start, no we.
- reset asserted after 5 values of 32 → we/op_done low next cycle, state IDLE; a new op_start with 16 values completes correctly.

Source files
------------

// File: rtl/glm_dot_unpack_pkg.sv
// Shared types and register-field positions for the GLM dot-result unpacker.
package glm_dot_unpack_pkg;
  typedef enum logic {
    STATE_IDLE    = 1'b0,
    STATE_PROCESS = 1'b1
  } t_unpackstate;

  localparam int CLDATA_WIDTH       = 512;
  localparam int REG_NUM_VALUES_LSB = 0;
  localparam int REG_NUM_VALUES_MSB = 15;
  localparam int REG_SKIP_FIRST_BIT = 0;
endpackage

// File: rtl/glm_dot_unpack_read_region2fifo.sv
// Region reader: looks up the region base in the property memory, then streams num_lines
// lines per iteration into a line FIFO; reads issue only while the FIFO has guaranteed room.
module read_region2fifo
  import glm_dot_unpack_pkg::*;
#(
  parameter int WIDTH      = CLDATA_WIDTH,
  parameter int LOG2_DEPTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_trigger,
  input  logic [15:0]      iterations,
  input  logic [31:0]      access_props,
  input  logic [15:0]      num_lines,
  output logic             props_re,
  output logic [15:0]      props_raddr,
  input  logic [31:0]      props_rdata,
  output logic             region_re,
  output logic [15:0]      region_raddr,
  input  logic [WIDTH-1:0] region_rdata,
  input  logic             fifo_re,
  output logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rvalid,
  output logic             fifo_empty
);
  localparam int DEPTH = 2**LOG2_DEPTH;

  logic                props_pend, region_pend, busy, has_room;
  logic [15:0]         base, line_idx, iter_cnt, iter_total, line_total;
  logic [LOG2_DEPTH:0] count;
  logic                unused_props;

  assign unused_props = ^{access_props[31:16], props_rdata[31:16]};
  // Count reads still travelling through the memory so the FIFO can never overflow.
  assign has_room = (32'(count) + 32'(region_re) + 32'(region_pend)) < DEPTH;

  always_ff @(posedge clk) begin
    if (reset) begin
      props_re     <= 1'b0;
      props_raddr  <= '0;
      props_pend   <= 1'b0;
      region_re    <= 1'b0;
      region_raddr <= '0;
      region_pend  <= 1'b0;
      busy         <= 1'b0;
      base         <= '0;
      line_idx     <= '0;
      iter_cnt     <= '0;
      iter_total   <= '0;
      line_total   <= '0;
    end else begin
      props_re    <= 1'b0;
      region_re   <= 1'b0;
      props_pend  <= props_re;
      region_pend <= region_re;
      if (read_trigger) begin
        props_re    <= 1'b1;
        props_raddr <= access_props[15:0];
        iter_total  <= iterations;
        line_total  <= num_lines;
      end
      if (props_pend) begin
        base     <= props_rdata[15:0];
        line_idx <= '0;
        iter_cnt <= '0;
        busy     <= (line_total != '0) && (iter_total != '0);
      end else if (busy && has_room) begin
        region_re    <= 1'b1;
        region_raddr <= base + line_idx;
        if (line_idx == line_total - 16'd1) begin
          line_idx <= '0;
          iter_cnt <= iter_cnt + 16'd1;
          if (iter_cnt == iter_total - 16'd1) busy <= 1'b0;
        end else begin
          line_idx <= line_idx + 16'd1;
        end
      end
    end
  end

  glm_fifo #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_line_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (region_pend),
    .push_dat (region_rdata),
    .pop      (fifo_re),
    .pop_dat  (fifo_rdata),
    .pop_vld  (fifo_rvalid),
    .empty    (fifo_empty),
    .count    (count)
  );
endmodule

// File: rtl/glm_fifo.sv
// Generic synchronous FIFO; registered pop output valid one cycle after pop.
// Pops on empty are ignored; the writer is responsible for never overfilling.
module glm_fifo #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_dat,
  input  logic                pop,
  output logic [WIDTH-1:0]    pop_dat,
  output logic                pop_vld,
  output logic                empty,
  output logic [LOG2_DEPTH:0] count
);
  logic [WIDTH-1:0]      mem [2**LOG2_DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic                  do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_vld <= 1'b0;
      pop_dat <= '0;
    end else begin
      pop_vld <= do_pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        pop_dat <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      count <= count + {{LOG2_DEPTH{1'b0}}, push} - {{LOG2_DEPTH{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/glm_dot_unpack.sv
// Unpacks 16x32-bit dot results per line into one scalar per cycle; rvalid->we 1 cycle,
// 2-cycle bubble between lines; almostfull freezes emission without dropping data.
module glm_dot_unpack
  import glm_dot_unpack_pkg::*;
#(
  parameter int LOG2_VALUES_PER_LINE = 4,
  parameter int LOG2_FIFO_DEPTH      = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_start,
  output logic                    op_done,
  input  logic [2:0][31:0]        regs,
  output logic                    mem_props_re,
  output logic [15:0]             mem_props_raddr,
  input  logic [31:0]             mem_props_rdata,
  output logic                    region_re,
  output logic [15:0]             region_raddr,
  input  logic [CLDATA_WIDTH-1:0] region_rdata,
  output logic                    to_consumer_we,
  output logic [31:0]             to_consumer_wdata,
  input  logic                    to_consumer_almostfull
);
  localparam int LW    = LOG2_VALUES_PER_LINE;
  localparam int LANES = 1 << LW;

  t_unpackstate            state, state_nxt;
  logic [15:0]             num_values, values_emitted, lines_needed, lines_fetched;
  logic [31:0]             props;
  logic                    skip_first, first_line, buf_valid, read_trigger, fifo_re;
  logic [LW-1:0]           lane, cur_lane;
  logic [CLDATA_WIDTH-1:0] line_buf, src_line, fifo_rdata;
  logic                    fifo_rvalid, fifo_empty;
  logic                    fetch, take, emit, last, lane_last;
  logic [15:0]             nv_in;
  logic                    skip_in;
  logic [17:0]             lines_calc;
  logic                    unused_bits;

  assign nv_in       = regs[0][REG_NUM_VALUES_MSB:REG_NUM_VALUES_LSB];
  assign skip_in     = regs[2][REG_SKIP_FIRST_BIT];
  assign unused_bits = ^{regs[0][31:16], regs[2][31:1], lines_calc[17:16]};

  always_comb begin
    state_nxt  = state;
    fetch      = 1'b0;
    take       = 1'b0;
    emit       = 1'b0;
    last       = 1'b0;
    lines_calc = (18'(nv_in) + 18'(skip_in) + 18'(LANES - 1)) >> LW;
    // A freshly returned line is emitted straight from the FIFO output while it loads.
    src_line   = fifo_rvalid ? fifo_rdata : line_buf;
    cur_lane   = fifo_rvalid ? {{(LW-1){1'b0}}, first_line & skip_first} : lane;
    lane_last  = (cur_lane == {LW{1'b1}});
    unique case (state)
      STATE_IDLE: begin
        if (op_start && nv_in != '0) state_nxt = STATE_PROCESS;
      end
      STATE_PROCESS: begin
        take  = fifo_rvalid;
        fetch = !fifo_empty && !fifo_re && !fifo_rvalid && !buf_valid &&
                (lines_fetched < lines_needed);
        emit  = (buf_valid || take) && !to_consumer_almostfull;
        last  = emit && (({1'b0, values_emitted} + 17'd1) == {1'b0, num_values});
        if (last) state_nxt = STATE_IDLE;
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= STATE_IDLE;
      op_done           <= 1'b0;
      to_consumer_we    <= 1'b0;
      to_consumer_wdata <= '0;
      read_trigger      <= 1'b0;
      fifo_re           <= 1'b0;
      num_values        <= '0;
      skip_first        <= 1'b0;
      props             <= '0;
      lines_needed      <= '0;
      values_emitted    <= '0;
      lines_fetched     <= '0;
      line_buf          <= '0;
      buf_valid         <= 1'b0;
      lane              <= '0;
      first_line        <= 1'b0;
    end else begin
      state          <= state_nxt;
      op_done        <= 1'b0;
      to_consumer_we <= 1'b0;
      read_trigger   <= 1'b0;
      fifo_re        <= fetch;
      if (state == STATE_IDLE && op_start) begin
        num_values     <= nv_in;
        skip_first     <= skip_in;
        props          <= regs[1];
        lines_needed   <= lines_calc[15:0];
        values_emitted <= '0;
        lines_fetched  <= '0;
        buf_valid      <= 1'b0;
        lane           <= '0;
        first_line     <= 1'b1;
        if (nv_in == '0) op_done <= 1'b1;
        else             read_trigger <= 1'b1;
      end
      if (take) begin
        line_buf      <= fifo_rdata;
        lines_fetched <= lines_fetched + 16'd1;
        first_line    <= 1'b0;
      end
      if (emit) begin
        to_consumer_we    <= 1'b1;
        to_consumer_wdata <= src_line[32*cur_lane +: 32];
        lane              <= cur_lane + 1'b1;
        values_emitted    <= values_emitted + 16'd1;
        buf_valid         <= !(lane_last || last);
        if (last) op_done <= 1'b1;
      end else if (take) begin
        buf_valid <= 1'b1;
        lane      <= cur_lane;
      end
    end
  end

  read_region2fifo #(.WIDTH(CLDATA_WIDTH), .LOG2_DEPTH(LOG2_FIFO_DEPTH)) u_reader (
    .clk          (clk),
    .reset        (reset),
    .read_trigger (read_trigger),
    .iterations   (16'd1),
    .access_props (props),
    .num_lines    (lines_needed),
    .props_re     (mem_props_re),
    .props_raddr  (mem_props_raddr),
    .props_rdata  (mem_props_rdata),
    .region_re    (region_re),
    .region_raddr (region_raddr),
    .region_rdata (region_rdata),
    .fifo_re      (fifo_re),
    .fifo_rdata   (fifo_rdata),
    .fifo_rvalid  (fifo_rvalid),
    .fifo_empty   (fifo_empty)
  );
endmodule

// File: tb/tb_glm_dot_unpack.sv
// Directed bench for glm_dot_unpack: region line a holds lane j = 16*a + j.
module tb_glm_dot_unpack;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             op_start = 1'b0;
  logic             op_done;
  logic [2:0][31:0] regs = '0;
  logic             mem_props_re;
  logic [15:0]      mem_props_raddr;
  logic [31:0]      mem_props_rdata = '0;
  logic             region_re;
  logic [15:0]      region_raddr;
  logic [511:0]     region_rdata = '0;
  logic             to_consumer_we;
  logic [31:0]      to_consumer_wdata;
  logic             to_consumer_almostfull = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] got[$];
  int done_cnt, done_cyc, first_we_cyc, last_we_cyc, region_re_cnt, props_re_cnt, start_cyc;
  logic [31:0] props_mem [4];

  glm_dot_unpack dut (
    .clk                    (clk),
    .reset                  (reset),
    .op_start               (op_start),
    .op_done                (op_done),
    .regs                   (regs),
    .mem_props_re           (mem_props_re),
    .mem_props_raddr        (mem_props_raddr),
    .mem_props_rdata        (mem_props_rdata),
    .region_re              (region_re),
    .region_raddr           (region_raddr),
    .region_rdata           (region_rdata),
    .to_consumer_we         (to_consumer_we),
    .to_consumer_wdata      (to_consumer_wdata),
    .to_consumer_almostfull (to_consumer_almostfull)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] line_data(input logic [15:0] a);
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = 32'(a) * 32'd16 + 32'(j);
    return d;
  endfunction

  // One-cycle-latency memories
  always @(posedge clk) begin
    if (mem_props_re) mem_props_rdata <= props_mem[mem_props_raddr[1:0]];
    if (region_re) region_rdata <= line_data(region_raddr);
  end

  always @(posedge clk) begin
    #2;
    if (to_consumer_we) begin
      if (got.size() == 0) first_we_cyc = cyc;
      got.push_back(to_consumer_wdata);
      last_we_cyc = cyc;
    end
    if (op_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (region_re) region_re_cnt++;
    if (mem_props_re) props_re_cnt++;
  end

  task automatic clear_mon();
    got.delete();
    done_cnt = 0; done_cyc = -1; first_we_cyc = -1; last_we_cyc = -1;
    region_re_cnt = 0; props_re_cnt = 0;
  endtask

  task automatic start_op(input int nv, input bit skip, input int pidx);
    @(negedge clk);
    clear_mon();
    regs[0] = 32'(nv);
    regs[1] = 32'(pidx);
    regs[2] = {31'b0, skip};
    op_start = 1'b1;
    @(posedge clk);
    #2;
    start_cyc = cyc;
    op_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (to_consumer_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", to_consumer_we); end
    total++; if (op_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", op_done); end
    total++; if (to_consumer_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", to_consumer_wdata); end
    total++; if (region_re !== 1'b0) begin bad++; $display("FAIL reset_region_re: got %b want 0", region_re); end
    total++; if (mem_props_re !== 1'b0) begin bad++; $display("FAIL reset_props_re: got %b want 0", mem_props_re); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_line();
    bit to;
    start_op(16, 1'b0, 0);
    wait_done(300, to);
    repeat (5) @(negedge clk);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout: got no op_done want op_done"); end
    total++; if (got.size() !== 16) begin bad++; $display("FAIL single_count: got %0d want 16", got.size()); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (k >= got.size()) begin bad++; $display("FAIL single_val[%0d]: got none want %0d", k, k); end
      else if (got[k] !== 32'(k)) begin bad++; $display("FAIL single_val[%0d]: got %0d want %0d", k, got[k], k); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cyc !== last_we_cyc) begin bad++; $display("FAIL single_done_with_we: got %0d want %0d", done_cyc, last_we_cyc); end
    total++; if (last_we_cyc - first_we_cyc !== 15) begin bad++; $display("FAIL single_span: got %0d want 15", last_we_cyc - first_we_cyc); end
    total++; if (region_re_cnt !== 1) begin bad++; $display("FAIL single_lines: got %0d want 1", region_re_cnt); end
  endtask

  task automatic test_two_lines();
    bit to;
    start_op(20, 1'b0, 0);
    wait_done(300, to);
    repeat (5) @(negedge clk);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL two_timeout: got no op_done want op_done"); end
    total++; if (got.size() !== 20) begin bad++; $display("FAIL two_count: got %0d want 20", got.size()); end
    for (int k = 0; k < 20; k++) begin
      total++;
      if (k >= got.size()) begin bad++; $display("FAIL two_val[%0d]: got none want %0d", k, k); end
      else if (got[k] !== 32'(k)) begin bad++; $display("FAIL two_val[%0d]: got %0d want %0d", k, got[k], k); end
    end
    total++; if (region_re_cnt !== 2) begin bad++; $display("FAIL two_lines: got %0d want 2", region_re_cnt); end
    // 19 value steps plus the 2-cycle bubble at the line boundary
    total++; if (last_we_cyc - first_we_cyc !== 21) begin bad++; $display("FAIL two_span: got %0d want 21", last_we_cyc - first_we_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL two_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_skip_first();
    bit to;
    start_op(16, 1'b1, 1);
    wait_done(300, to);
    repeat (5) @(negedge clk);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL skip_timeout: got no op_done want op_done"); end
    total++; if (got.size() !== 16) begin bad++; $display("FAIL skip_count: got %0d want 16", got.size()); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (k >= got.size()) begin bad++; $display("FAIL skip_val[%0d]: got none want %0d", k, 65 + k); end
      else if (got[k] !== 32'(65 + k)) begin bad++; $display("FAIL skip_val[%0d]: got %0d want %0d", k, got[k], 65 + k); end
    end
    total++; if (region_re_cnt !== 2) begin bad++; $display("FAIL skip_lines: got %0d want 2", region_re_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    int n0;
    start_op(32, 1'b0, 0);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (got.size() >= 5) begin to = 1'b0; break; end
    end
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_start: got %0d values want 5", got.size()); end
    to_consumer_almostfull = 1'b1;
    n0 = got.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (to_consumer_we !== 1'b0) begin bad++; $display("FAIL bp_hold_we[%0d]: got %b want 0", i, to_consumer_we); end
    end
    total++; if (got.size() !== n0) begin bad++; $display("FAIL bp_frozen: got %0d want %0d", got.size(), n0); end
    to_consumer_almostfull = 1'b0;
    wait_done(300, to);
    repeat (5) @(negedge clk);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout: got no op_done want op_done"); end
    total++; if (got.size() !== 32) begin bad++; $display("FAIL bp_count: got %0d want 32", got.size()); end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (k >= got.size()) begin bad++; $display("FAIL bp_val[%0d]: got none want %0d", k, k); end
      else if (got[k] !== 32'(k)) begin bad++; $display("FAIL bp_val[%0d]: got %0d want %0d", k, got[k], k); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_values();
    start_op(0, 1'b0, 0);
    repeat (12) @(negedge clk);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cyc !== start_cyc) begin bad++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, start_cyc); end
    total++; if (got.size() !== 0) begin bad++; $display("FAIL zero_we: got %0d want 0", got.size()); end
    total++; if (props_re_cnt !== 0) begin bad++; $display("FAIL zero_trigger: got %0d want 0", props_re_cnt); end
    total++; if (region_re_cnt !== 0) begin bad++; $display("FAIL zero_lines: got %0d want 0", region_re_cnt); end
  endtask

  task automatic test_reset_midop();
    bit to;
    start_op(32, 1'b0, 0);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (got.size() >= 5) begin to = 1'b0; break; end
    end
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rst_start: got %0d values want 5", got.size()); end
    reset = 1'b1;
    @(posedge clk);
    #2;
    total++; if (to_consumer_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", to_consumer_we); end
    total++; if (op_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", op_done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", done_cnt); end
    total++; if (got.size() !== 5) begin bad++; $display("FAIL rst_no_more: got %0d want 5", got.size()); end
    start_op(16, 1'b0, 2);
    wait_done(300, to);
    repeat (5) @(negedge clk);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rst_redo_timeout: got no op_done want op_done"); end
    total++; if (got.size() !== 16) begin bad++; $display("FAIL rst_redo_count: got %0d want 16", got.size()); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (k >= got.size()) begin bad++; $display("FAIL rst_redo_val[%0d]: got none want %0d", k, 128 + k); end
      else if (got[k] !== 32'(128 + k)) begin bad++; $display("FAIL rst_redo_val[%0d]: got %0d want %0d", k, got[k], 128 + k); end
    end
    total++; if (region_re_cnt !== 1) begin bad++; $display("FAIL rst_redo_lines: got %0d want 1", region_re_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rst_redo_done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    props_mem[0] = 32'd0;
    props_mem[1] = 32'd4;
    props_mem[2] = 32'd8;
    props_mem[3] = 32'd12;
    clear_mon();
    test_reset();
    test_single_line();
    test_two_lines();
    test_skip_first();
    test_backpressure();
    test_zero_values();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end
endmodule
